// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder menu controller: rotation browses a bank of parameter registers,
// a press opens an edit of the selected one, a second press commits it.
module encoder_param_ctrl #(
    parameter int N_PARAMS      = 4,
    parameter int VAL_W         = 8,
    parameter int VAL_MAX       = 255,
    parameter int INIT_VAL      = 0,
    parameter int WRAP          = 0,
    parameter int TIMEOUT_TICKS = 100000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cw,
    input  logic                          ccw,
    input  logic                          prs,
    output logic [$clog2(N_PARAMS)-1:0]   sel,
    output logic                          edit,
    output logic [VAL_W-1:0]              cur_val,
    output logic [N_PARAMS*VAL_W-1:0]     params,
    output logic                          upd,
    output logic [$clog2(N_PARAMS)-1:0]   upd_idx,
    output logic [VAL_W-1:0]              upd_val
);

    localparam int SEL_W = $clog2(N_PARAMS);
    localparam int CNT_W = $clog2(TIMEOUT_TICKS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PARAMS - 1);
    localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(VAL_MAX);
    localparam logic [VAL_W-1:0] INIT_V   = VAL_W'(INIT_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic {
        BROWSE = 1'b0,
        EDIT   = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [SEL_W-1:0]                sel_q, sel_d;
    logic [VAL_W-1:0]                work_q, work_d;
    logic [N_PARAMS-1:0][VAL_W-1:0]  params_q, params_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            upd_q, upd_d;
    logic [SEL_W-1:0]                upd_idx_q, upd_idx_d;
    logic [VAL_W-1:0]                upd_val_q, upd_val_d;
    logic [VAL_W-1:0]                cur_val_q, cur_val_d;

    logic             step_up;
    logic             step_dn;
    logic [VAL_W-1:0] inc_val;
    logic [VAL_W-1:0] dec_val;

    // Opposing rotation in one cycle cancels; the saturate/wrap choice is fixed at elaboration.
    always_comb begin
        step_up = cw & ~ccw;
        step_dn = ccw & ~cw;
        inc_val = work_q + 1'b1;
        dec_val = work_q - 1'b1;
        if (work_q >= MAX_V) begin
            inc_val = (WRAP != 0) ? '0 : MAX_V;
        end
        if (work_q == '0) begin
            dec_val = (WRAP != 0) ? MAX_V : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        work_d    = work_q;
        params_d  = params_q;
        cnt_d     = '0;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        upd_val_d = upd_val_q;

        case (state_q)
            BROWSE: begin
                if (prs) begin
                    state_d = EDIT;
                    work_d  = params_q[sel_q];
                end else if (step_up) begin
                    sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end else if (step_dn) begin
                    sel_d = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
                end
            end
            EDIT: begin
                if (prs) begin
                    params_d[sel_q] = work_q;
                    upd_d           = 1'b1;
                    upd_idx_d       = sel_q;
                    upd_val_d       = work_q;
                    state_d         = BROWSE;
                end else if (cw || ccw) begin
                    if (step_up) begin
                        work_d = inc_val;
                    end else if (step_dn) begin
                        work_d = dec_val;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = BROWSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BROWSE;
            end
        endcase

        // Registered so the displayed value tracks the state it will be shown with.
        cur_val_d = (state_d == EDIT) ? work_d : params_d[sel_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BROWSE;
            sel_q     <= '0;
            work_q    <= INIT_V;
            params_q  <= {N_PARAMS{INIT_V}};
            cnt_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            upd_val_q <= '0;
            cur_val_q <= INIT_V;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            work_q    <= work_d;
            params_q  <= params_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            upd_val_q <= upd_val_d;
            cur_val_q <= cur_val_d;
        end
    end

    assign sel     = sel_q;
    assign edit    = (state_q == EDIT);
    assign cur_val = cur_val_q;
    assign params  = params_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign upd_val = upd_val_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Bench for encoder_param_ctrl: a saturating and a wrapping instance share one stimulus
// stream; a scoreboard checks every cycle and directed checks pin the key scenarios.
module tb_encoder_param_ctrl;

    localparam int NP    = 4;
    localparam int VW    = 8;
    localparam int VMAX  = 255;
    localparam int INITV = 0;
    localparam int TT    = 16;

    logic clk = 1'b0;
    logic rst, cw, ccw, prs;

    logic [1:0]  sel0, sel1, uidx0, uidx1;
    logic        edit0, edit1, upd0, upd1;
    logic [7:0]  cur0, cur1, uval0, uval1;
    logic [31:0] params0, params1;

    typedef struct packed {
        logic [1:0]      sel;
        logic            edit;
        logic [7:0]      work;
        logic [3:0][7:0] par;
        logic [4:0]      cnt;
        logic            upd;
        logic [1:0]      uidx;
        logic [7:0]      uval;
    } model_t;

    typedef logic [53:0] obs_t;

    model_t m0, m1;
    obs_t   exp_q[$];
    obs_t   obs0, obs1;
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;

    always #5 clk = ~clk;

    encoder_param_ctrl #(
        .N_PARAMS(NP), .VAL_W(VW), .VAL_MAX(VMAX), .INIT_VAL(INITV),
        .WRAP(0), .TIMEOUT_TICKS(TT)
    ) dut_sat (
        .clk(clk), .rst(rst), .cw(cw), .ccw(ccw), .prs(prs),
        .sel(sel0), .edit(edit0), .cur_val(cur0), .params(params0),
        .upd(upd0), .upd_idx(uidx0), .upd_val(uval0)
    );

    encoder_param_ctrl #(
        .N_PARAMS(NP), .VAL_W(VW), .VAL_MAX(VMAX), .INIT_VAL(INITV),
        .WRAP(1), .TIMEOUT_TICKS(TT)
    ) dut_wrap (
        .clk(clk), .rst(rst), .cw(cw), .ccw(ccw), .prs(prs),
        .sel(sel1), .edit(edit1), .cur_val(cur1), .params(params1),
        .upd(upd1), .upd_idx(uidx1), .upd_val(uval1)
    );

    assign obs0 = {sel0, edit0, cur0, params0, upd0, uidx0, uval0};
    assign obs1 = {sel1, edit1, cur1, params1, upd1, uidx1, uval1};

    // Reference behaviour of one controller for one clock edge.
    function automatic model_t stepModel(model_t s, bit wrap, bit c, bit cc, bit p, bit r);
        model_t n;
        n = s;
        n.upd = 1'b0;
        if (r) begin
            n.sel  = 2'd0;
            n.edit = 1'b0;
            n.work = 8'(INITV);
            for (int i = 0; i < NP; i++) n.par[i] = 8'(INITV);
            n.cnt  = 5'd0;
            n.uidx = 2'd0;
            n.uval = 8'd0;
            return n;
        end
        if (!s.edit) begin
            n.cnt = 5'd0;
            if (p) begin
                n.edit = 1'b1;
                n.work = s.par[s.sel];
            end else if (c && !cc) begin
                n.sel = (s.sel == 2'd3) ? 2'd0 : s.sel + 2'd1;
            end else if (cc && !c) begin
                n.sel = (s.sel == 2'd0) ? 2'd3 : s.sel - 2'd1;
            end
        end else if (p) begin
            n.par[s.sel] = s.work;
            n.upd  = 1'b1;
            n.uidx = s.sel;
            n.uval = s.work;
            n.edit = 1'b0;
            n.cnt  = 5'd0;
        end else if (c || cc) begin
            n.cnt = 5'd0;
            if (c && !cc) begin
                if (s.work == 8'(VMAX)) n.work = wrap ? 8'd0 : 8'(VMAX);
                else                    n.work = s.work + 8'd1;
            end else if (cc && !c) begin
                if (s.work == 8'd0) n.work = wrap ? 8'(VMAX) : 8'd0;
                else                n.work = s.work - 8'd1;
            end
        end else if (s.cnt == 5'(TT - 1)) begin
            n.edit = 1'b0;
            n.cnt  = 5'd0;
        end else begin
            n.cnt = s.cnt + 5'd1;
        end
        return n;
    endfunction

    function automatic obs_t expOf(model_t s);
        logic [7:0] cv;
        cv = s.edit ? s.work : s.par[s.sel];
        return {s.sel, s.edit, cv, s.par, s.upd, s.uidx, s.uval};
    endfunction

    task automatic checkOutput();
        obs_t e0, e1;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        n_cmp++;
        assert (obs0 === e0) else begin
            n_err++;
            $error("[TB] FAIL sb_sat cycle %0d observed=%h expected=%h", cyc, obs0, e0);
        end
        n_cmp++;
        assert (obs1 === e1) else begin
            n_err++;
            $error("[TB] FAIL sb_wrap cycle %0d observed=%h expected=%h", cyc, obs1, e1);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit c, input bit cc, input bit p, input bit r);
        cw  = c;
        ccw = cc;
        prs = p;
        rst = r;
        m0 = stepModel(m0, 1'b0, c, cc, p, r);
        m1 = stepModel(m1, 1'b1, c, cc, p, r);
        exp_q.push_back(expOf(m0));
        exp_q.push_back(expOf(m1));
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int exp_sel[5];
        int rv;
        exp_sel = '{3, 2, 1, 0, 3};
        m0  = '0;
        m1  = '0;
        cw  = 1'b0;
        ccw = 1'b0;
        prs = 1'b0;
        rst = 1'b1;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkValue("reset_sel", 32'(sel0), 32'd0);
        checkValue("reset_edit", 32'(edit0), 32'd0);
        checkValue("reset_params", params0, 32'd0);
        checkValue("reset_upd", 32'(upd0), 32'd0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] browse wrap");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkValue($sformatf("browse_ccw%0d", i), 32'(sel0), 32'(exp_sel[i]));
        end
        applyStimulus(1, 0, 0, 0);
        checkValue("browse_cw_wrap", 32'(sel0), 32'd0);

        $display("[TB] edit and commit");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkValue("select_2", 32'(sel0), 32'd2);
        applyStimulus(0, 0, 1, 0);
        checkValue("enter_edit", 32'(edit0), 32'd1);
        repeat (3) applyStimulus(1, 0, 0, 0);
        checkValue("edit_value", 32'(cur0), 32'd3);
        applyStimulus(0, 0, 1, 0);
        checkValue("commit_upd", 32'(upd0), 32'd1);
        checkValue("commit_idx", 32'(uidx0), 32'd2);
        checkValue("commit_val", 32'(uval0), 32'd3);
        checkValue("commit_params", params0, 32'h0003_0000);
        checkValue("commit_edit", 32'(edit0), 32'd0);
        idle(1);
        checkValue("upd_one_cycle", 32'(upd0), 32'd0);

        $display("[TB] bounds");
        applyStimulus(0, 0, 1, 0);
        repeat (4) applyStimulus(0, 1, 0, 0);
        checkValue("sat_low", 32'(cur0), 32'd0);
        checkValue("wrap_low", 32'(cur1), 32'd255);
        repeat (254) applyStimulus(1, 0, 0, 0);
        checkValue("climb_254", 32'(cur0), 32'd254);
        repeat (3) applyStimulus(1, 0, 0, 0);
        checkValue("sat_high", 32'(cur0), 32'd255);
        checkValue("wrap_high", 32'(cur1), 32'd0);
        applyStimulus(0, 0, 1, 0);
        checkValue("bound_commit_sat", params0, 32'h00FF_0000);
        checkValue("bound_commit_wrap", params1, 32'h0000_0000);
        idle(1);

        $display("[TB] timeout");
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        idle(TT - 1);
        checkValue("timeout_not_yet", 32'(edit0), 32'd1);
        idle(1);
        checkValue("timeout_exit", 32'(edit0), 32'd0);
        checkValue("timeout_no_upd", 32'(upd0), 32'd0);
        checkValue("timeout_params_sat", params0, 32'h00FF_0000);
        checkValue("timeout_params_wrap", params1, 32'h0000_0000);
        applyStimulus(0, 0, 1, 0);
        idle(TT - 1);
        applyStimulus(1, 0, 0, 0);
        checkValue("timeout_event_priority", 32'(edit0), 32'd1);
        idle(TT - 1);
        checkValue("timeout_restarted", 32'(edit0), 32'd1);
        idle(1);
        checkValue("timeout_second_exit", 32'(edit0), 32'd0);

        $display("[TB] simultaneous events");
        applyStimulus(1, 1, 0, 0);
        checkValue("both_browse", 32'(sel0), 32'd2);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0);
        checkValue("both_edit", 32'(cur0), 32'd255);
        applyStimulus(0, 0, 1, 0);
        checkValue("commit_unchanged", 32'(upd0), 32'd1);
        applyStimulus(1, 0, 1, 0);
        checkValue("prs_cw_edit", 32'(edit0), 32'd1);
        checkValue("prs_cw_sel", 32'(sel0), 32'd2);

        $display("[TB] reset mid-edit");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkValue("midreset_edit", 32'(edit0), 32'd0);
        checkValue("midreset_params_sat", params0, 32'd0);
        checkValue("midreset_params_wrap", params1, 32'd0);

        $display("[TB] random traffic");
        repeat (400) begin
            rv = int'($urandom_range(0, 199));
            applyStimulus(rv < 30, rv >= 20 && rv < 50, rv >= 50 && rv < 62, rv == 199);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
